// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM states and the
// three-sample majority vote used by the oversampling receivers.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_RECOVER
    } rx_state_t;

    function automatic logic majority3(
        input logic a,
        input logic b,
        input logic c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Sample-tick divider: one-clk tick every CLK_DIV clocks.
// Held at zero while clr is high so the tick phase follows its release.
module uart_tick_gen #(
    parameter int CLK_DIV = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // count 0..CLK_DIV-1, tick on the last count
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // divider register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority-voted mid-bit sampling and
// a one-entry valid/ready output buffer carrying framing/parity flags.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 27,
    parameter int OVS       = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int OW = $clog2(OVS);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [OW-1:0] SMP_A   = OW'(OVS / 2 - 1);
    localparam logic [OW-1:0] SMP_B   = OW'(OVS / 2);
    localparam logic [OW-1:0] SMP_C   = OW'(OVS / 2 + 1);
    localparam logic [OW-1:0] OS_LAST = OW'(OVS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    // sync_q[0]: first stage, [1]: synced rx, [2]: previous synced rx
    logic [2:0] sync_q, sync_d;
    logic       rx_s;
    logic       fall;

    rx_state_t state_q, state_d;
    logic [OW-1:0] os_cnt_q, os_cnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic          stop_cnt_q, stop_cnt_d;
    logic [1:0]    smp_q, smp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic ferr_q, ferr_d;
    logic perr_q, perr_d;
    logic commit_q, commit_d;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic valid_q, valid_d;
    logic fe_q, fe_d;
    logic pe_q, pe_d;
    logic ovr_q, ovr_d;

    logic tick;
    logic tick_clr;
    logic vote;
    logic vote_now;

    assign rx_s     = sync_q[1];
    assign fall     = sync_q[2] & ~sync_q[1];
    assign tick_clr = (state_q == S_IDLE);
    assign vote     = majority3(smp_q[1], smp_q[0], rx_s);
    assign vote_now = tick && (os_cnt_q == SMP_C);

    uart_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clr  (tick_clr),
        .tick (tick)
    );

    // synchroniser and edge-detect history
    always_comb begin
        sync_d = {sync_q[1:0], rx};
    end

    // receive FSM, sample window, shift register and frame flags
    always_comb begin
        state_d    = state_q;
        os_cnt_d   = os_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        smp_d      = smp_q;
        shift_d    = shift_q;
        ferr_d     = ferr_q;
        perr_d     = perr_q;
        commit_d   = 1'b0;

        if (tick) begin
            if (os_cnt_q == OS_LAST) os_cnt_d = '0;
            else                     os_cnt_d = os_cnt_q + OW'(1);
        end
        if (tick && (os_cnt_q == SMP_A || os_cnt_q == SMP_B)) begin
            smp_d = {smp_q[0], rx_s};
        end

        unique case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d    = S_START;
                    ferr_d     = 1'b0;
                    perr_d     = 1'b0;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                end
            end
            S_START: begin
                if (vote_now) begin
                    state_d = vote ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (vote_now) begin
                    shift_d   = {vote, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != PARITY_NONE) ? S_PAR : S_STOP;
                    end
                end
            end
            S_PAR: begin
                if (vote_now) begin
                    perr_d  = ((^shift_q) ^ vote) != (PARITY == PARITY_ODD);
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (vote_now) begin
                    ferr_d = ferr_q | ~vote;
                    if (stop_cnt_q == STOP_LAST) begin
                        commit_d = 1'b1;
                        state_d  = (ferr_q | ~vote) ? S_RECOVER : S_IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            S_RECOVER: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_IDLE) os_cnt_d = '0;
    end

    // output buffer: load on commit, clear on handshake, flag overrun
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        fe_d    = fe_q;
        pe_d    = pe_q;
        ovr_d   = 1'b0;
        if (commit_q) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                fe_d    = ferr_q;
                pe_d    = perr_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q     <= 3'b111;
            state_q    <= S_IDLE;
            os_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            smp_q      <= '0;
            shift_q    <= '0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            commit_q   <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            fe_q       <= 1'b0;
            pe_q       <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            os_cnt_q   <= os_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            smp_q      <= smp_d;
            shift_q    <= shift_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
            commit_q   <= commit_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            fe_q       <= fe_d;
            pe_q       <= pe_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign frame_err  = fe_q;
    assign parity_err = pe_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: 8N1 instance plus an even-parity
// instance, CLK_DIV=2 and OVS=16 giving 32 clocks per bit.
module tb_uart_rx_os;

    localparam int BIT = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err, overrun, busy;

    logic       rx_p = 1'b1;
    logic       ready_p = 1'b1;
    logic [7:0] rx_data_p;
    logic       rx_valid_p, frame_err_p, parity_err_p, overrun_p, busy_p;

    int errors = 0;
    int checks = 0;

    int         xfer = 0;
    int         vcyc = 0;
    int         ovr_n = 0;
    logic [7:0] last_data = 8'h00;
    logic       last_fe = 1'b0;
    logic       last_pe = 1'b0;

    int         xfer_p = 0;
    int         ovr_p_n = 0;
    logic [7:0] last_data_p = 8'h00;
    logic       last_fe_p = 1'b0;
    logic       last_pe_p = 1'b0;

    always #5 clk = ~clk;

    uart_rx_os #(
        .CLK_DIV(2), .OVS(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) u_dut (
        .clk(clk), .reset(reset), .rx(rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .parity_err(parity_err),
        .overrun(overrun), .busy(busy)
    );

    uart_rx_os #(
        .CLK_DIV(2), .OVS(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
    ) u_dut_p (
        .clk(clk), .reset(reset), .rx(rx_p),
        .rx_data(rx_data_p), .rx_valid(rx_valid_p), .rx_ready(ready_p),
        .frame_err(frame_err_p), .parity_err(parity_err_p),
        .overrun(overrun_p), .busy(busy_p)
    );

    // observe handshakes and pulses away from the active edge
    always @(negedge clk) begin
        if (rx_valid) vcyc <= vcyc + 1;
        if (overrun) ovr_n <= ovr_n + 1;
        if (rx_valid && rx_ready) begin
            xfer      <= xfer + 1;
            last_data <= rx_data;
            last_fe   <= frame_err;
            last_pe   <= parity_err;
        end
        if (overrun_p) ovr_p_n <= ovr_p_n + 1;
        if (rx_valid_p && ready_p) begin
            xfer_p      <= xfer_p + 1;
            last_data_p <= rx_data_p;
            last_fe_p   <= frame_err_p;
            last_pe_p   <= parity_err_p;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input bit sel, input logic b);
        if (sel) rx_p = b;
        else     rx = b;
        repeat (BIT) @(posedge clk);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d,
                              input bit par_en, input logic par_b,
                              input logic stop_b, input int stop_n);
        send_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
        if (par_en) send_bit(sel, par_b);
        for (int i = 0; i < stop_n; i++) send_bit(sel, stop_b);
        if (sel) rx_p = 1'b1;
        else     rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int x0;
        int v0;
        int o0;
        int xp0;
        bit seen;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_ovr", overrun, 0);
        reset = 1'b1;
        rx_ready = 1'b1;
        repeat (4) @(posedge clk);

        // 8N1 0xA5 with consumer always ready
        x0 = xfer;
        v0 = vcyc;
        send_frame(0, 8'hA5, 0, 1'b0, 1'b1, 1);
        idle(20);
        chk("a5_xfer", xfer - x0, 1);
        chk("a5_vcyc", vcyc - v0, 1);
        chk("a5_data", last_data, 8'hA5);
        chk("a5_fe", last_fe, 0);
        chk("a5_pe", last_pe, 0);

        // short low glitch is rejected at the start-bit vote
        x0 = xfer;
        rx = 1'b0;
        repeat (10) @(posedge clk);
        rx = 1'b1;
        @(negedge clk);
        chk("glitch_busy_hi", busy, 1);
        idle(60);
        chk("glitch_busy_lo", busy, 0);
        chk("glitch_xfer", xfer - x0, 0);

        // even parity: wrong then correct parity bit for 0x03
        xp0 = xfer_p;
        send_frame(1, 8'h03, 1, 1'b1, 1'b1, 1);
        idle(20);
        chk("par_bad_xfer", xfer_p - xp0, 1);
        chk("par_bad_data", last_data_p, 8'h03);
        chk("par_bad_pe", last_pe_p, 1);
        send_frame(1, 8'h03, 1, 1'b0, 1'b1, 1);
        idle(20);
        chk("par_ok_xfer", xfer_p - xp0, 2);
        chk("par_ok_pe", last_pe_p, 0);
        chk("par_ok_fe", last_fe_p, 0);
        chk("par_ovr", ovr_p_n, 0);

        // overrun: consumer stalled across two frames
        rx_ready = 1'b0;
        o0 = ovr_n;
        send_frame(0, 8'h11, 0, 1'b0, 1'b1, 1);
        send_frame(0, 8'h22, 0, 1'b0, 1'b1, 1);
        idle(20);
        chk("ovr_count", ovr_n - o0, 1);
        chk("ovr_valid", rx_valid, 1);
        chk("ovr_data", rx_data, 8'h11);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        @(negedge clk);
        chk("drain_valid", rx_valid, 0);

        // drain in the commit cycle: new word replaces old, no overrun
        send_frame(0, 8'h11, 0, 1'b0, 1'b1, 1);
        idle(10);
        o0 = ovr_n;
        seen = 1'b0;
        fork
            send_frame(0, 8'h22, 0, 1'b0, 1'b1, 1);
            begin
                for (int i = 0; i < 400 && !seen; i++) begin
                    @(negedge clk);
                    if (u_dut.commit_q) seen = 1'b1;
                end
                if (seen) begin
                    #1 rx_ready = 1'b1;
                    @(posedge clk);
                    #1 rx_ready = 1'b0;
                end
            end
        join
        chk("commit_seen", seen, 1);
        idle(10);
        chk("same_ovr", ovr_n - o0, 0);
        chk("same_valid", rx_valid, 1);
        chk("same_data", rx_data, 8'h22);
        rx_ready = 1'b1;
        idle(5);

        // stop bit held low, then recovery and a clean frame
        x0 = xfer;
        send_frame(0, 8'h0F, 0, 1'b0, 1'b0, 3);
        rx = 1'b0;
        @(negedge clk);
        chk("fe_busy", busy, 1);
        chk("fe_data", last_data, 8'h0F);
        chk("fe_flag", last_fe, 1);
        send_bit(0, 1'b1);
        @(negedge clk);
        chk("rec_busy", busy, 0);
        send_frame(0, 8'h55, 0, 1'b0, 1'b1, 1);
        idle(20);
        chk("rec_xfer", xfer - x0, 2);
        chk("rec_data", last_data, 8'h55);
        chk("rec_fe", last_fe, 0);

        // reset during the data bits
        send_bit(0, 1'b0);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        @(negedge clk);
        chk("mid_busy", busy, 1);
        chk("mid_data_pre", rx_data, 8'h55);
        #2 reset = 1'b0;
        rx = 1'b1;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_data", rx_data, 0);
        chk("mrst_valid", rx_valid, 0);
        chk("mrst_fe", frame_err, 0);
        chk("mrst_pe", parity_err, 0);
        chk("mrst_ovr", overrun, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2 * BIT) @(posedge clk);
        x0 = xfer;
        send_frame(0, 8'h3C, 0, 1'b0, 1'b1, 1);
        idle(20);
        chk("post_xfer", xfer - x0, 1);
        chk("post_data", last_data, 8'h3C);
        chk("post_fe", last_fe, 0);
        chk("post_busy_p", busy_p, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
